// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - decode/issue stage with busy scoreboard and immediate formatting
// Optional DECODE_WB_BYPASS_EN: same-cycle writeback releases a stalled instruction.
module decode_issue_stage #(
    parameter  int XLEN  = 36,
    parameter  int ILEN  = 32,
    parameter  int NREGS = 32,
    parameter  int IMMW  = 25,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [ILEN-1:0] if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic [3:0]      imm_type,
    input  logic            src1_en,
    input  logic            src2_en,
    input  logic            dst_en,
    input  logic [AW-1:0]   src1_addr,
    input  logic [AW-1:0]   src2_addr,
    input  logic [AW-1:0]   dst_addr,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [IMMW-1:0] id_imm,
    output logic [AW-1:0]   id_src1,
    output logic [AW-1:0]   id_src2,
    output logic [AW-1:0]   id_dst,
    output logic            id_dst_en
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [NREGS-1:0] busy_eff;
    logic [IMMW-1:0]  imm_next;
    logic             hazard;
    logic             accept;

`ifdef DECODE_WB_BYPASS_EN
    always_comb begin
        busy_eff = busy;
        if (wb_valid && wb_addr != '0) busy_eff[wb_addr] = 1'b0;
    end
`else
    assign busy_eff = busy;
`endif

    assign hazard   = (src1_en & busy_eff[src1_addr]) |
                      (src2_en & busy_eff[src2_addr]) |
                      (dst_en  & busy_eff[dst_addr]);
    assign if_ready = !rst && !flush && !hazard && (!id_valid || id_ready);
    assign accept   = if_valid && if_ready;

    // Later assignments win: a new issue overrides a same-cycle retire of that register.
    always_comb begin
        busy_next = busy;
        if (wb_valid && wb_addr != '0) busy_next[wb_addr] = 1'b0;
        if (flush && id_valid && !id_ready && id_dst_en && id_dst != '0) busy_next[id_dst] = 1'b0;
        if (accept && dst_en && dst_addr != '0) busy_next[dst_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Fill with the field's sign bit, then overwrite the low bits with the field.
    always_comb begin
        imm_next = '0;
        case (imm_type)
            4'd0: begin
                imm_next       = {IMMW{if_inst[24]}};
                imm_next[24:0] = if_inst[24:0];
            end
            4'd1: begin
                imm_next       = {IMMW{if_inst[24]}};
                imm_next[20:0] = {if_inst[24:20], if_inst[15:0]};
            end
            4'd2: begin
                imm_next       = {IMMW{if_inst[21]}};
                imm_next[21:0] = if_inst[21:0];
            end
            4'd3: begin
                imm_next       = {IMMW{if_inst[14]}};
                imm_next[14:0] = if_inst[14:0];
            end
            4'd4: begin
                imm_next       = {IMMW{if_inst[18]}};
                imm_next[18:0] = if_inst[18:0];
            end
            4'd5: begin
                imm_next       = {IMMW{if_inst[24]}};
                imm_next[14:0] = {if_inst[24:20], if_inst[9:0]};
            end
            4'd6: begin
                imm_next       = {IMMW{if_inst[14]}};
                imm_next[10:0] = if_inst[14:4];
            end
            4'd7: begin
                imm_next       = {IMMW{if_inst[24]}};
                imm_next[15:0] = {if_inst[24:20], if_inst[14:4]};
            end
            4'd8: begin
                imm_next       = {IMMW{if_inst[24]}};
                imm_next[10:0] = {if_inst[24:20], if_inst[9:4]};
            end
            default: imm_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            id_valid  <= 1'b0;
            id_inst   <= '0;
            id_pc     <= '0;
            id_imm    <= '0;
            id_src1   <= '0;
            id_src2   <= '0;
            id_dst    <= '0;
            id_dst_en <= 1'b0;
        end else begin
            busy <= busy_next;
            if (flush) begin
                id_valid <= 1'b0;
            end else if (accept) begin
                id_valid <= 1'b1;
            end else if (id_ready) begin
                id_valid <= 1'b0;
            end
            if (accept) begin
                id_inst   <= if_inst;
                id_pc     <= if_pc;
                id_imm    <= imm_next;
                id_src1   <= src1_addr;
                id_src2   <= src2_addr;
                id_dst    <= dst_addr;
                id_dst_en <= dst_en;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb/tb_decode_issue_stage.sv - directed self-checking bench for decode_issue_stage
module tb_decode_issue_stage;

    localparam int XLEN  = 36;
    localparam int ILEN  = 32;
    localparam int NREGS = 32;
    localparam int IMMW  = 25;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid;
    logic            if_ready;
    logic [ILEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc;
    logic [3:0]      imm_type;
    logic            src1_en, src2_en, dst_en;
    logic [AW-1:0]   src1_addr, src2_addr, dst_addr;
    logic            flush;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic            id_valid;
    logic            id_ready;
    logic [ILEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc;
    logic [IMMW-1:0] id_imm;
    logic [AW-1:0]   id_src1, id_src2, id_dst;
    logic            id_dst_en;

    int n_checks = 0;
    int n_pass   = 0;

    decode_issue_stage #(
        .XLEN(XLEN), .ILEN(ILEN), .NREGS(NREGS), .IMMW(IMMW)
    ) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .imm_type(imm_type),
        .src1_en(src1_en), .src2_en(src2_en), .dst_en(dst_en),
        .src1_addr(src1_addr), .src2_addr(src2_addr), .dst_addr(dst_addr),
        .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
        .id_imm(id_imm), .id_src1(id_src1), .id_src2(id_src2), .id_dst(id_dst),
        .id_dst_en(id_dst_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [ILEN-1:0] inst,
                         input logic [3:0] it, input logic s1e, input logic [AW-1:0] s1,
                         input logic de, input logic [AW-1:0] d);
        if_valid  = v;
        if_pc     = pc;
        if_inst   = inst;
        imm_type  = it;
        src1_en   = s1e;
        src1_addr = s1;
        src2_en   = 1'b0;
        src2_addr = '0;
        dst_en    = de;
        dst_addr  = d;
    endtask

    // I0 writes r; I1 reads r (RAW) or writes r (WAW) and must wait for writeback of r.
    task automatic hazard_case(input string tag, input logic waw, input logic [AW-1:0] r,
                               input logic [XLEN-1:0] pc);
        drive(1'b1, pc, 32'h11, 4'd0, 1'b0, '0, 1'b1, r);
        #1 check({tag, "_i0_ready"}, if_ready, 1);
        tick;
        drive(1'b1, pc + 4, 32'h22, 4'd0, !waw, r, waw, r);
        #1;
        for (int i = 0; i < 2; i++) begin
            check({tag, "_stall"}, if_ready, 0);
            tick;
        end
        wb_valid = 1'b1;
        wb_addr  = r;
        #1;
`ifdef DECODE_WB_BYPASS_EN
        check({tag, "_wb_cycle_ready"}, if_ready, 1);
        tick;
        wb_valid = 1'b0;
`else
        check({tag, "_wb_cycle_ready"}, if_ready, 0);
        tick;
        wb_valid = 1'b0;
        #1 check({tag, "_after_wb_ready"}, if_ready, 1);
        tick;
`endif
        check({tag, "_i1_pc"}, id_pc, pc + 4);
        check({tag, "_i1_valid"}, id_valid, 1);
        if_valid = 1'b0;
        tick;
        if (waw) begin
            wb_valid = 1'b1;
            wb_addr  = r;
            tick;
            wb_valid = 1'b0;
        end
    endtask

    initial begin
        logic [IMMW-1:0] imm_exp [4];
        logic [ILEN-1:0] imm_inst [4];
        logic [3:0]      imm_t [4];
        imm_inst[0] = 32'h0100_0000; imm_t[0] = 4'd5;  imm_exp[0] = 25'h1FFC000;
        imm_inst[1] = 32'hFFFF_FFFF; imm_t[1] = 4'd12; imm_exp[1] = 25'h0000000;
        imm_inst[2] = 32'h00FF_FFFF; imm_t[2] = 4'd0;  imm_exp[2] = 25'h0FFFFFF;
        imm_inst[3] = 32'h0000_4010; imm_t[3] = 4'd6;  imm_exp[3] = 25'h1FFFC01;

        rst      = 1'b1;
        flush    = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        id_ready = 1'b1;
        drive(1'b1, 36'h0_0000_0100, 32'hDEAD_BEEF, 4'd0, 1'b0, '0, 1'b0, '0);

        for (int i = 0; i < 2; i++) begin
            tick;
            check("rst_if_ready", if_ready, 0);
            check("rst_id_valid", id_valid, 0);
        end
        check("rst_id_pc", id_pc, 0);
        check("rst_id_imm", id_imm, 0);
        check("rst_id_inst", id_inst, 0);
        rst = 1'b0;

        // Back-to-back issue, one instruction per cycle, also covering immediate formats.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 36'h1_0000_0100 + 36'(i * 4), imm_inst[i], imm_t[i], 1'b0, '0, 1'b0, '0);
            #1 check("b2b_if_ready", if_ready, 1);
            tick;
            check("b2b_id_valid", id_valid, 1);
            check("b2b_id_pc", id_pc, 36'h1_0000_0100 + 36'(i * 4));
            check("b2b_id_inst", id_inst, imm_inst[i]);
            check("imm", id_imm, imm_exp[i]);
        end
        if_valid = 1'b0;
        tick;
        check("drain_id_valid", id_valid, 0);

        hazard_case("raw", 1'b0, 5'd5, 36'h200);
        hazard_case("waw", 1'b1, 5'd5, 36'h240);

        // r0 is never tracked busy.
        drive(1'b1, 36'h280, 32'h33, 4'd0, 1'b0, '0, 1'b1, 5'd0);
        tick;
        drive(1'b1, 36'h284, 32'h34, 4'd0, 1'b1, 5'd0, 1'b0, '0);
        #1 check("r0_no_hazard", if_ready, 1);
        tick;
        check("r0_id_pc", id_pc, 36'h284);
        if_valid = 1'b0;
        tick;

        // Backpressure holds outputs stable.
        id_ready = 1'b0;
        drive(1'b1, 36'h300, 32'hCAFE_0001, 4'd3, 1'b0, '0, 1'b0, '0);
        tick;
        drive(1'b1, 36'h304, 32'hCAFE_0002, 4'd3, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_if_ready", if_ready, 0);
            check("bp_id_pc", id_pc, 36'h300);
            check("bp_id_inst", id_inst, 32'hCAFE_0001);
            check("bp_id_valid", id_valid, 1);
            tick;
        end
        id_ready = 1'b1;
        #1 check("bp_resume_ready", if_ready, 1);
        tick;
        check("bp_resume_pc", id_pc, 36'h304);
        if_valid = 1'b0;
        tick;

        // Flush of a stalled instruction releases its destination.
        id_ready = 1'b0;
        drive(1'b1, 36'h400, 32'h44, 4'd0, 1'b0, '0, 1'b1, 5'd7);
        tick;
        check("fl_held_valid", id_valid, 1);
        if_valid = 1'b0;
        flush    = 1'b1;
        #1 check("fl_if_ready", if_ready, 0);
        tick;
        flush    = 1'b0;
        check("fl_id_valid", id_valid, 0);
        id_ready = 1'b1;
        drive(1'b1, 36'h404, 32'h45, 4'd0, 1'b1, 5'd7, 1'b0, '0);
        #1 check("fl_r7_released", if_ready, 1);
        tick;
        check("fl_next_pc", id_pc, 36'h404);
        if_valid = 1'b0;

        // Flush after the instruction has transferred keeps its busy bit.
        drive(1'b1, 36'h500, 32'h55, 4'd0, 1'b0, '0, 1'b1, 5'd8);
        tick;
        if_valid = 1'b0;
        flush    = 1'b1;
        tick;
        flush    = 1'b0;
        drive(1'b1, 36'h504, 32'h56, 4'd0, 1'b1, 5'd8, 1'b0, '0);
        #1 check("fl_xfer_busy_kept", if_ready, 0);
        wb_valid = 1'b1;
        wb_addr  = 5'd8;
        tick;
        wb_valid = 1'b0;
        #1 check("fl_xfer_released", if_ready, 1);
        tick;
        check("fl_xfer_pc", id_pc, 36'h504);
        if_valid = 1'b0;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
